// File: rtl/fpu_addsub_requester_if.sv
// Request/response bus between a host and the FPU add/subtract requester.
// The requester is the slave on both channels; the host is the master.
interface fpu_addsub_requester_if #(
  parameter int W = 32
);
  logic         req_valid_i;
  logic         req_ready_o;
  logic [W-1:0] req_x_i;
  logic [W-1:0] req_y_i;
  logic         req_op_i;
  logic [1:0]   req_rmode_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] rsp_result_o;
  logic         rsp_ovf_o;
  logic         rsp_udf_o;
  logic         rsp_timeout_o;

  modport slave (
    input  req_valid_i, req_x_i, req_y_i, req_op_i, req_rmode_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_ovf_o, rsp_udf_o, rsp_timeout_o
  );

  modport master (
    output req_valid_i, req_x_i, req_y_i, req_op_i, req_rmode_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_ovf_o, rsp_udf_o, rsp_timeout_o
  );
endinterface

// File: rtl/fpu_addsub_requester.sv
// Host-side initiator for the FPU add/subtract unit: launches one operation at a
// time with beg_FSM, waits for ready (with a watchdog), acks, and returns a response.
module fpu_addsub_requester #(
  parameter int          W        = 32,
  parameter int          TIMEOUT  = 64,
  parameter int          CW       = 7,
  parameter logic [15:0] CNT_INIT = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fpu_addsub_requester_if.slave bus,
  output logic          beg_FSM,
  output logic          ack_FSM,
  output logic [W-1:0]  Data_X,
  output logic [W-1:0]  Data_Y,
  output logic          add_subt,
  output logic [1:0]    r_mode,
  input  logic          ready,
  input  logic [W-1:0]  final_result_ieee,
  input  logic          overflow_flag,
  input  logic          underflow_flag,
  output logic [15:0]   op_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ACK    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wd, w_wd_nxt;
  logic [W-1:0]  r_data_x, w_data_x;
  logic [W-1:0]  r_data_y, w_data_y;
  logic          r_op, w_op;
  logic [1:0]    r_rmode, w_rmode;
  logic [W-1:0]  r_result, w_result;
  logic          r_ovf, w_ovf;
  logic          r_udf, w_udf;
  logic          r_tmo, w_tmo;
  logic [15:0]   r_count, w_count;
  logic          r_beg, r_ack, r_req_ready, r_rsp_valid;

  // Next-state and next-value logic for the operation sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_data_x    = r_data_x;
    w_data_y    = r_data_y;
    w_op        = r_op;
    w_rmode     = r_rmode;
    w_result    = r_result;
    w_ovf       = r_ovf;
    w_udf       = r_udf;
    w_tmo       = r_tmo;
    w_count     = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_data_x    = bus.req_x_i;
          w_data_y    = bus.req_y_i;
          w_op        = bus.req_op_i;
          w_rmode     = bus.req_rmode_i;
          w_state_nxt = S_LAUNCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_wd_nxt    = {CW{1'b0}};
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_wd_nxt = r_wd + CW'(1);
        // ready has priority over a watchdog expiry in the same cycle
        if (ready) begin
          w_result    = final_result_ieee;
          w_ovf       = overflow_flag;
          w_udf       = underflow_flag;
          w_tmo       = 1'b0;
          w_state_nxt = S_ACK;
        end else if (r_wd == WD_LAST) begin
          w_result    = {W{1'b0}};
          w_ovf       = 1'b0;
          w_udf       = 1'b0;
          w_tmo       = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_ACK: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          w_count     = r_count + 16'd1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; strobes are decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wd        <= {CW{1'b0}};
      r_data_x    <= {W{1'b0}};
      r_data_y    <= {W{1'b0}};
      r_op        <= 1'b0;
      r_rmode     <= 2'b00;
      r_result    <= {W{1'b0}};
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_tmo       <= 1'b0;
      r_count     <= CNT_INIT;
      r_beg       <= 1'b0;
      r_ack       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wd        <= w_wd_nxt;
      r_data_x    <= w_data_x;
      r_data_y    <= w_data_y;
      r_op        <= w_op;
      r_rmode     <= w_rmode;
      r_result    <= w_result;
      r_ovf       <= w_ovf;
      r_udf       <= w_udf;
      r_tmo       <= w_tmo;
      r_count     <= w_count;
      r_beg       <= (w_state_nxt == S_LAUNCH);
      r_ack       <= (w_state_nxt == S_ACK);
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
    end
  end

  assign bus.req_ready_o   = r_req_ready;
  assign bus.rsp_valid_o   = r_rsp_valid;
  assign bus.rsp_result_o  = r_result;
  assign bus.rsp_ovf_o     = r_ovf;
  assign bus.rsp_udf_o     = r_udf;
  assign bus.rsp_timeout_o = r_tmo;
  assign beg_FSM           = r_beg;
  assign ack_FSM           = r_ack;
  assign Data_X            = r_data_x;
  assign Data_Y            = r_data_y;
  assign add_subt          = r_op;
  assign r_mode            = r_rmode;
  assign op_count_o        = r_count;

endmodule

// File: doc/fpu_addsub_requester.md
Name: fpu_addsub_requester

Overview:
- Host-side initiator for the FPU add/subtract unit; the other end of its beg_FSM / ready / ack_FSM handshake.
- Accepts operand requests on a valid/ready interface, holds the operands stable, and pulses beg_FSM to start an operation.
- Waits for ready, captures result and flags, pulses ack_FSM to return the FPU FSM to idle, then presents a response on a valid/ready interface.
- Includes a watchdog timeout and a completed-operation counter.

Parameters:
- W, 32, IEEE word width (32 single, 64 double).
- TIMEOUT, 64, max WAIT-state cycles before abort; must be ≥2.
- CW, 7, watchdog counter width; requires 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  requester can accept
- req_x_i  in  W  operand X
- req_y_i  in  W  operand Y
- req_op_i  in  1  0=add, 1=subtract
- req_rmode_i  in  2  rounding mode
- beg_FSM  out  1  start pulse to FPU
- ack_FSM  out  1  acknowledge pulse to FPU
- Data_X  out  W  operand X to FPU
- Data_Y  out  W  operand Y to FPU
- add_subt  out  1  operation to FPU
- r_mode  out  2  rounding mode to FPU
- ready  in  1  FPU done (held until ack_FSM)
- final_result_ieee  in  W  FPU result
- overflow_flag  in  1  FPU overflow
- underflow_flag  in  1  FPU underflow
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_result_o  out  W  captured result
- rsp_ovf_o  out  1  captured overflow
- rsp_udf_o  out  1  captured underflow
- rsp_timeout_o  out  1  operation aborted by watchdog
- op_count_o  out  16  completed responses, wraps at 0xFFFF→0

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; all outputs are registered.
- Reset values:
  - req_ready_o=1 (IDLE); every other output = 0.
  - State=IDLE, watchdog=0, op_count_o=0.
  - Reset asserted in any state overrides everything; no ack_FSM is issued on reset.
- States: IDLE, LAUNCH, WAIT, ACK, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: register x, y, op, rmode onto Data_X/Data_Y/add_subt/r_mode; go to LAUNCH.
- LAUNCH:
  - beg_FSM=1 for exactly this cycle; watchdog cleared; go to WAIT.
  - ready is ignored in this cycle.
- WAIT:
  - Watchdog increments each cycle.
  - If ready=1: capture final_result_ieee, overflow_flag, underflow_flag; timeout flag=0; go to ACK.
  - Else if watchdog==TIMEOUT-1: capture result=0, ovf=0, udf=0, timeout=1; go to ACK.
  - If ready and expiry coincide, ready wins.
- ACK:
  - ack_FSM=1 for exactly this cycle; go to RESP.
- RESP:
  - rsp_valid_o=1 with captured fields held stable.
  - When rsp_ready_i=1: go to IDLE and increment op_count_o.
  - If rsp_ready_i is already high on the first RESP cycle, the handshake completes in that cycle.
- Data_X/Data_Y/add_subt/r_mode stay constant from LAUNCH through ACK and keep their last value in IDLE.
- req_ready_o=0 in every state except IDLE; single outstanding operation, no buffering.
- Minimum accept-to-rsp_valid latency: 4 cycles (accept→LAUNCH→WAIT with ready→ACK→RESP).
- Back-to-back throughput: one operation per (FPU latency + 4) cycles.
- ready is sampled only in WAIT. A stale ready high in IDLE/LAUNCH has no effect.
- beg_FSM and ack_FSM are never high in the same cycle and are never high for more than one consecutive cycle.

Test Plan:
- Add: X=0x3F800000, Y=0x40000000, op=0, rmode=0; FPU stub asserts ready after 12 cycles with 0x40400000 → exactly one beg_FSM pulse, one ack_FSM pulse one cycle after ready is seen, rsp_result_o=0x40400000, rsp_timeout_o=0, op_count_o=1.
- Subtract plus backpressure: X=0x40400000, Y=0x3F800000, op=1; rsp_ready_i low for 10 cycles → rsp_valid_o held with rsp_result_o=0x40000000 unchanged, req_ready_o=0 throughout; IDLE one cycle after rsp_ready_i rises.
- Watchdog: stub never asserts ready → ack_FSM pulses after 64 WAIT cycles, rsp_timeout_o=1, rsp_result_o=0; a following add 1.0+2.0 completes normally.
- Flags and race: stub returns 0x7F800000 with overflow_flag=1, and ready rises exactly on the expiry cycle → rsp_ovf_o=1, rsp_timeout_o=0.
- Reset in WAIT: assert rst for 1 cycle → next cycle all outputs 0, req_ready_o=1, no ack_FSM; a stale ready=1 in IDLE causes no response.
- Back-to-back: 3 requests with req_valid_i held high, rsp_ready_i=1 → 3 beg_FSM pulses, 3 responses in order, op_count_o=3; op_count_o preloaded to 0xFFFF then one op → wraps to 0.
